// File: rtl/host_input_port_if.sv
// Host/core handshake bundle for host_input_port: host push side and per-core read side.
// No logic of its own; carries the signals between the host, the cores and the port.
// Backpressure on the host side is in_valid/in_ready; the core side is request/grant.
interface host_input_port_if #(
    parameter int NUM_CORES  = 8,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_val;
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_CORES-1:0]  core_read_req;
    logic [NUM_CORES-1:0]  core_read_grant;
    logic [DATA_WIDTH-1:0] core_read_data;

    // Host and cores drive words and requests; they observe ready, grants and data.
    modport master (
        output in_val,
        output in_valid,
        output core_read_req,
        input  in_ready,
        input  core_read_grant,
        input  core_read_data
    );

    // The port itself accepts words and requests and returns ready, grants and data.
    modport slave (
        input  in_val,
        input  in_valid,
        input  core_read_req,
        output in_ready,
        output core_read_grant,
        output core_read_data
    );
endinterface

// File: rtl/host_input_port.sv
// Host-to-core input channel: FIFO fed by the host, drained one word per cycle to a round-robin granted core.
// Latency: a word pushed at edge N is grantable at edge N+1; a grant plus its data appear one cycle after the edge and last one cycle.
// Backpressure: in_ready drops while the FIFO is full (count-based); define HOST_INPUT_PORT_LEVEL_EN to expose fifo_level.
module host_input_port #(
    parameter int NUM_CORES  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    host_input_port_if.slave              bus
`ifdef HOST_INPUT_PORT_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [AW:0]          FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [RW-1:0]        LAST_CORE = RW'(NUM_CORES - 1);
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = {{(NUM_CORES - 1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [RW-1:0]         r_rr_ptr;
    logic [NUM_CORES-1:0]  r_grant;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_CORES-1:0]  w_eff_req;
    logic                  w_found;
    logic [RW-1:0]         w_sel;
    logic [RW-1:0]         w_idx;
    int                    w_scan;

    // Ready comes purely from the registered count, so a pop cannot open a slot in the same cycle.
    assign w_in_ready = (r_count != FULL_CNT);
    assign w_push     = bus.in_valid && w_in_ready;

    // A core holding its request while it sees its grant is skipped for that one edge.
    assign w_eff_req  = bus.core_read_req & ~r_grant;

    // Round-robin search: first requesting core at or above the RR pointer, wrapping to core 0.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        w_scan  = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_CORES) begin
                w_scan = w_scan - NUM_CORES;
            end
            w_idx = RW'(w_scan);
            if (!w_found && w_eff_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Nothing to hand out when empty; a word written this edge is not visible to the search yet.
    assign w_pop = (r_count != '0) && w_found;

    // Storage array; contents are don't-care until written, emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_val;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap on overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Grant pulse, delivered word and RR pointer; data and pointer hold when nobody is served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else if (w_pop) begin
            r_grant  <= ONE_HOT0 << w_sel;
            r_data   <= r_mem[r_rd_ptr];
            r_rr_ptr <= (w_sel == LAST_CORE) ? '0 : w_sel + 1'b1;
        end else begin
            r_grant  <= '0;
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.core_read_grant = r_grant;
    assign bus.core_read_data  = r_data;

`ifdef HOST_INPUT_PORT_LEVEL_EN
    assign fifo_level = r_count;
`endif

endmodule

// File: tb/tb_host_input_port.sv
module tb_host_input_port;

    localparam int N     = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    host_input_port_if #(.NUM_CORES(N), .DATA_WIDTH(DW)) bus ();

`ifdef HOST_INPUT_PORT_LEVEL_EN
    logic [3:0] fifo_level;
`endif

    host_input_port #(
        .NUM_CORES (N),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef HOST_INPUT_PORT_LEVEL_EN
        ,
        .fifo_level(fifo_level)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of words, a next-priority index and the last grant.
    logic [DW-1:0] m_q [$];
    logic [N-1:0]  m_grant;
    logic [DW-1:0] m_data;
    int            m_rr;

    task automatic model_reset();
        m_q.delete();
        m_grant = '0;
        m_data  = '0;
        m_rr    = 0;
    endtask

    // Advance the model by one edge using the current inputs, then move to 1ns after the edge.
    task automatic tick();
        logic         push;
        logic         served;
        logic [N-1:0] eff;
        int           idx;
        push   = bus.in_valid && (m_q.size() < DEPTH);
        eff    = bus.core_read_req & ~m_grant;
        served = 1'b0;
        if (m_q.size() > 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!served && eff[3'(idx)]) begin
                    served = 1'b1;
                    m_grant = '0;
                    m_grant[3'(idx)] = 1'b1;
                    m_data = m_q.pop_front();
                    m_rr = (idx + 1) % N;
                end
            end
        end
        if (!served) m_grant = '0;
        if (push) m_q.push_back(bus.in_val);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_val        = '0;
        bus.core_read_req = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_val   = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_val = 16'($urandom);
        bus.core_read_req = 8'hFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.core_read_grant !== 8'h00) begin
            errors++; $display("FAIL reset_grant: got %h expected 00", bus.core_read_grant);
        end
        checks++;
        if (bus.core_read_data !== 16'h0000) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", bus.core_read_data);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
        end
`ifdef HOST_INPUT_PORT_LEVEL_EN
        checks++;
        if (fifo_level !== 4'd0) begin
            errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level);
        end
`endif
        bus.in_valid = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.core_read_grant !== 8'h00) begin
                errors++; $display("FAIL reset_empty_grant: cycle %0d got %h expected 00", c, bus.core_read_grant);
            end
        end
        idle_inputs();
    endtask

    task automatic test_ordering();
        logic [DW-1:0] words [3];
        logic got;
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        do_reset();
        for (int i = 0; i < 3; i++) push_word(words[i]);
        for (int i = 0; i < 3; i++) begin
            bus.core_read_req = 8'h04;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                if (bus.core_read_grant !== 8'h00) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL order_timeout: word %0d got no grant expected 04", i);
            end else begin
                checks++;
                if (bus.core_read_grant !== 8'h04) begin
                    errors++; $display("FAIL order_grant: word %0d got %h expected 04", i, bus.core_read_grant);
                end
                checks++;
                if (bus.core_read_data !== words[i]) begin
                    errors++; $display("FAIL order_data: word %0d got %h expected %h", i, bus.core_read_data, words[i]);
                end
            end
            bus.core_read_req = 8'h00;
            tick();
            checks++;
            if (bus.core_read_grant !== 8'h00) begin
                errors++; $display("FAIL order_pulse: word %0d got %h expected 00", i, bus.core_read_grant);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] words [4];
        logic [N-1:0]  exp_g [4];
        exp_g[0] = 8'h01; exp_g[1] = 8'h04; exp_g[2] = 8'h80; exp_g[3] = 8'h01;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            words[i] = 16'($urandom);
            push_word(words[i]);
        end
        bus.core_read_req = 8'b1000_0101;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.core_read_grant !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant: step %0d got %h expected %h", i, bus.core_read_grant, exp_g[i]);
            end
            checks++;
            if (bus.core_read_data !== words[i]) begin
                errors++; $display("FAIL rr_data: step %0d got %h expected %h", i, bus.core_read_data, words[i]);
            end
        end
        tick();
        checks++;
        if (bus.core_read_grant !== 8'h00) begin
            errors++; $display("FAIL rr_empty: got %h expected 00", bus.core_read_grant);
        end
        idle_inputs();
    endtask

    task automatic test_full();
        logic [DW-1:0] words [8];
        int n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            words[i] = 16'($urandom);
            push_word(words[i]);
            checks++;
            if (bus.in_ready !== (i < 7)) begin
                errors++; $display("FAIL full_ready: after push %0d got %b expected %b", i, bus.in_ready, (i < 7));
            end
        end
        bus.in_valid = 1'b1;
        bus.in_val   = 16'h9999;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ninth_ready: got %b expected 0", bus.in_ready);
        end
`ifdef HOST_INPUT_PORT_LEVEL_EN
        checks++;
        if (fifo_level !== 4'd8) begin
            errors++; $display("FAIL full_level: got %0d expected 8", fifo_level);
        end
`endif
        bus.core_read_req = 8'h01;
        tick();
        checks++;
        if (bus.core_read_grant !== 8'h01 || bus.core_read_data !== words[0]) begin
            errors++; $display("FAIL full_pop: got %h/%h expected 01/%h", bus.core_read_grant, bus.core_read_data, words[0]);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_ready_after_pop: got %b expected 1", bus.in_ready);
        end
`ifdef HOST_INPUT_PORT_LEVEL_EN
        checks++;
        if (fifo_level !== 4'd7) begin
            errors++; $display("FAIL full_level_after_pop: got %0d expected 7", fifo_level);
        end
`endif
        idle_inputs();
        tick();
        bus.core_read_req = 8'hFF;
        n = 0;
        for (int t = 0; t < 30 && n < 7; t++) begin
            tick();
            if (bus.core_read_grant !== 8'h00) begin
                checks++;
                if (bus.core_read_data !== words[n + 1]) begin
                    errors++; $display("FAIL full_drain_data: word %0d got %h expected %h", n + 1, bus.core_read_data, words[n + 1]);
                end
                n++;
            end
        end
        checks++;
        if (n != 7) begin
            errors++; $display("FAIL full_drain_count: got %0d words expected 7", n);
        end
        tick();
        checks++;
        if (bus.core_read_grant !== 8'h00) begin
            errors++; $display("FAIL full_ninth_taken: got grant %h expected 00", bus.core_read_grant);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] words [3];
        logic [DW-1:0] seen [$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            words[i] = 16'($urandom);
            push_word(words[i]);
        end
        bus.in_valid = 1'b1;
        bus.in_val = 16'hABCD;
        bus.core_read_req = 8'h02;
        tick();
        checks++;
        if (bus.core_read_grant !== 8'h02 || bus.core_read_data !== words[0]) begin
            errors++; $display("FAIL simul_grant: got %h/%h expected 02/%h", bus.core_read_grant, bus.core_read_data, words[0]);
        end
`ifdef HOST_INPUT_PORT_LEVEL_EN
        checks++;
        if (fifo_level !== 4'd3) begin
            errors++; $display("FAIL simul_level: got %0d expected 3", fifo_level);
        end
`endif
        seen.push_back(bus.core_read_data);
        idle_inputs();
        bus.core_read_req = 8'hFF;
        for (int t = 0; t < 20 && seen.size() < 4; t++) begin
            tick();
            if (bus.core_read_grant !== 8'h00) seen.push_back(bus.core_read_data);
        end
        checks++;
        if (seen.size() != 4) begin
            errors++; $display("FAIL simul_count: got %0d words expected 4", seen.size());
        end else begin
            checks++;
            if (seen[3] !== 16'hABCD) begin
                errors++; $display("FAIL simul_fourth: got %h expected abcd", seen[3]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push_word(16'($urandom));
        bus.core_read_req = 8'hFF;
        tick();
        checks++;
        if (bus.core_read_grant !== 8'h01) begin
            errors++; $display("FAIL mid_pre_grant: got %h expected 01", bus.core_read_grant);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.core_read_grant !== 8'h00 || bus.core_read_data !== 16'h0000 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_async: got grant %h data %h ready %b expected 00/0000/1",
                               bus.core_read_grant, bus.core_read_data, bus.in_ready);
        end
        #4;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.core_read_grant !== 8'h00) begin
                errors++; $display("FAIL mid_empty: cycle %0d got %h expected 00", c, bus.core_read_grant);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid      = ($urandom_range(0, 9) < 6);
            bus.in_val        = 16'($urandom);
            bus.core_read_req = 8'($urandom & $urandom & $urandom);
            tick();
            checks++;
            if (bus.core_read_grant !== m_grant || bus.core_read_data !== m_data) begin
                errors++; $display("FAIL rand_out: cycle %0d got %h/%h expected %h/%h",
                                   c, bus.core_read_grant, bus.core_read_data, m_grant, m_data);
            end
            checks++;
            if (bus.in_ready !== (m_q.size() != DEPTH)) begin
                errors++; $display("FAIL rand_ready: cycle %0d got %b expected %b", c, bus.in_ready, (m_q.size() != DEPTH));
            end
`ifdef HOST_INPUT_PORT_LEVEL_EN
            checks++;
            if (fifo_level !== 4'(m_q.size())) begin
                errors++; $display("FAIL rand_level: cycle %0d got %0d expected %0d", c, fifo_level, m_q.size());
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_ordering();
        test_round_robin();
        test_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/host_input_port.md
Name: host_input_port

Overview:
- Input channel into the core cluster; the counterpart of the cluster's output_val/output_enable path.
- Host side pushes 16-bit words through a valid/ready handshake into an internal FIFO.
- Up to NUM_CORES cores request words; a round-robin arbiter grants one core per cycle and delivers the FIFO head word to it.
- Sits in top beside the cluster, driven by the testbench or external host.

Parameters:
NUM_CORES, 8, number of core-side requesters
DATA_WIDTH, 16, word width
FIFO_DEPTH, 8, FIFO entries; must be a power of two and >= 2

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_val  input  DATA_WIDTH  host word
in_valid  input  1  host word present
in_ready  output  1  FIFO can accept a word
core_read_req  input  NUM_CORES  per-core request (level)
core_read_grant  output  NUM_CORES  one-hot grant pulse; all zero when idle
core_read_data  output  DATA_WIDTH  word for the granted core; valid only while a grant bit is high

Behaviour:
Reset:
- While reset=0: FIFO empty, count=0, read and write pointers=0, RR pointer=0, core_read_grant=0, core_read_data=0, in_ready=1.
- Reset mid-operation discards all buffered words and any pending grant immediately; it is asynchronous.

Push:
- in_ready = (count != FIFO_DEPTH). It is combinational from registered count and has no dependency on in_valid or pops.
- A word is accepted at a rising edge when in_valid && in_ready. It is written at the write pointer, and the pointer increments mod FIFO_DEPTH.

Arbitration:
- eff_req = core_read_req & ~core_read_grant. A core seeing its grant this cycle is not re-granted at the next edge even if its req is still high.
- At each edge, if count != 0 and eff_req != 0, select the first set bit of eff_req, searching upward from the RR pointer index and wrapping NUM_CORES-1 to 0.
- On a selection:
  - core_read_grant <= one-hot(sel)
  - core_read_data <= FIFO[rd_ptr]
  - rd_ptr increments mod FIFO_DEPTH
  - RR pointer <= (sel+1) mod NUM_CORES
- Otherwise core_read_grant <= 0, while core_read_data and the RR pointer hold.
- Latency: a req asserted before edge N, with FIFO non-empty at edge N, produces a grant and data visible after edge N, lasting exactly one cycle.
- The core drops req on seeing its grant. A req still held in the following cycle is masked for one cycle only.

Count:
- count' = count + push - pop.
- Simultaneous push and pop when 0 < count < FIFO_DEPTH leaves count unchanged.
- When full, a pop in the same cycle does not enable a push; in_ready stays low that cycle.
- Empty: no grant is issued, and a word pushed at edge N is first grantable at edge N+1 (no fall-through).
- Pointers wrap naturally; the full/empty decision uses count, not pointer compare.

Optional Feature:
- Macro: HOST_INPUT_PORT_LEVEL_EN
- With it defined: adds output port fifo_level, width $clog2(FIFO_DEPTH)+1, equal to registered count. It resets to 0 and updates at the same edge as count.
- Without it: the port is absent and the behaviour is otherwise identical.

Test Plan:
1. Reset: hold reset=0 with in_valid=1 and req=8'hFF -> grant=0, data=0, in_ready=1, nothing is stored. Release reset with no pushes -> grant stays 0 while the FIFO is empty.
2. Ordering: push 16'h1111, 16'h2222, 16'h3333; core2 holds req until it sees its grant, then deasserts; repeat for each word -> three single-cycle grants of 8'h04, in order, with data 1111, 2222, 3333.
3. Round-robin: FIFO holds 4 words, req=8'b1000_0101 held constant -> grants in the order core0, core2, core7, core0. No core receives two consecutive grants.
4. Full: push 8 words with no reqs -> in_ready=0 after the 8th accept, and a 9th in_valid word is not taken. Then one grant fires -> in_ready=1 the next cycle, and level=7 with HOST_INPUT_PORT_LEVEL_EN.
5. Simultaneous: count=3, push 16'hABCD while core1 is granted -> count stays 3, and 16'hABCD is the 4th word delivered.
6. Reset mid-stream: 5 words buffered and a grant active, then reset pulsed low for half a cycle -> grant clears immediately, and the FIFO is empty afterwards (no grants despite req).
